// File: rtl/pipe_ctrl_stage.sv
// Two-entry skid buffer carrying the E->M control bundle, with bubble insertion,
// synchronous flush and a saturating count of backpressured cycles.
module pipe_ctrl_stage #(
    parameter int unsigned           CTRL_W  = 4,
    parameter int unsigned           CNT_W   = 8,
    parameter logic [CTRL_W-1:0]     NOP_VAL = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    input  logic              out_ready_i,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    logic              main_valid_q, main_valid_d;
    logic [CTRL_W-1:0] main_data_q, main_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_data_q, skid_data_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic in_xfer;
    logic out_xfer;

    assign in_ready_o  = !skid_valid_q;
    assign out_valid_o = main_valid_q;
    assign out_ctrl_o  = main_valid_q ? main_data_q : NOP_VAL;
    assign stall_cnt_o = stall_cnt_q;

    assign in_xfer  = in_valid_i && in_ready_o;
    assign out_xfer = main_valid_q && out_ready_i;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_xfer) begin
            // in_ready_o is low whenever skid is full, so no input can race the refill
            if (skid_valid_q) begin
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (in_xfer) begin
                main_data_d = in_ctrl_i;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            if (!main_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = in_ctrl_i;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_ctrl_i;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_valid_q && !out_ready_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_valid_q <= 1'b0;
            main_data_q  <= NOP_VAL;
            skid_valid_q <= 1'b0;
            skid_data_q  <= NOP_VAL;
            stall_cnt_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_stage.sv
// Randomized plus directed bench for pipe_ctrl_stage against a FIFO-queue reference model.
module tb_pipe_ctrl_stage;

    localparam int unsigned CTRL_W  = 4;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              flush_i;
    logic              in_valid_i;
    logic [CTRL_W-1:0] in_ctrl_i;
    logic              in_ready_o;
    logic              out_valid_o;
    logic [CTRL_W-1:0] out_ctrl_o;
    logic              out_ready_i;
    logic [CNT_W-1:0]  stall_cnt_o;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference: in-flight bundles in order, at most two, plus the stall count.
    logic [CTRL_W-1:0] mq[$];
    int unsigned       mcnt = 0;

    pipe_ctrl_stage #(
        .CTRL_W (CTRL_W),
        .CNT_W  (CNT_W),
        .NOP_VAL('0)
    ) u_dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .in_valid_i (in_valid_i),
        .in_ctrl_i  (in_ctrl_i),
        .in_ready_o (in_ready_o),
        .out_valid_o(out_valid_o),
        .out_ctrl_o (out_ctrl_o),
        .out_ready_i(out_ready_i),
        .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [CTRL_W-1:0] exp_ctrl;
        exp_ctrl = (mq.size() > 0) ? mq[0] : '0;
        check("in_ready", {31'd0, in_ready_o}, {31'd0, mq.size() < 2});
        check("out_valid", {31'd0, out_valid_o}, {31'd0, mq.size() > 0});
        check("out_ctrl", 32'(out_ctrl_o), 32'(exp_ctrl));
        check("stall_cnt", 32'(stall_cnt_o), mcnt);
    endtask

    // Check at negedge, then advance the model across the rising edge.
    task automatic cycle();
        bit rdy;
        bit ov;
        @(negedge clk_i);
        check_outputs();
        @(posedge clk_i);
        rdy = mq.size() < 2;
        ov  = mq.size() > 0;
        if (ov && !out_ready_i && mcnt < CNT_MAX) mcnt++;
        if (flush_i) begin
            mq.delete();
        end else begin
            if (ov && out_ready_i) void'(mq.pop_front());
            if (in_valid_i && rdy) mq.push_back(in_ctrl_i);
        end
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        mq.delete();
        mcnt = 0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic offer(input logic v, input logic [CTRL_W-1:0] c, input logic rdy);
        in_valid_i  = v;
        in_ctrl_i   = c;
        out_ready_i = rdy;
        cycle();
    endtask

    initial begin
        int unsigned sat_exp[6];
        sat_exp = '{1, 2, 3, 3, 3, 3};
        rst_i       = 1'b1;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        in_ctrl_i   = '0;
        out_ready_i = 1'b0;
        #3;
        check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        check("rst_out_ctrl", 32'(out_ctrl_o), 32'd0);
        check("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
        check("rst_stall", 32'(stall_cnt_o), 32'd0);
        do_reset();

        // Streaming
        offer(1'b1, 4'hA, 1'b1);
        offer(1'b1, 4'h5, 1'b1);
        offer(1'b1, 4'hF, 1'b1);
        offer(1'b0, 4'h0, 1'b1);
        offer(1'b0, 4'h0, 1'b1);

        // Backpressure into skid, then drain
        offer(1'b1, 4'hA, 1'b0);
        offer(1'b1, 4'h5, 1'b0);
        offer(1'b1, 4'h7, 1'b0);
        offer(1'b0, 4'h0, 1'b0);
        offer(1'b0, 4'h0, 1'b1);
        offer(1'b0, 4'h0, 1'b1);
        offer(1'b0, 4'h0, 1'b1);

        // Flush with a full buffer and a competing input
        offer(1'b1, 4'hA, 1'b0);
        offer(1'b1, 4'h5, 1'b0);
        flush_i = 1'b1;
        offer(1'b1, 4'h3, 1'b0);
        flush_i = 1'b0;
        check("flush_out_valid", {31'd0, out_valid_o}, 32'd0);
        check("flush_out_ctrl", 32'(out_ctrl_o), 32'd0);
        offer(1'b0, 4'h0, 1'b1);
        check("flush_no_3", {31'd0, out_valid_o}, 32'd0);

        // Bubble
        offer(1'b0, 4'hF, 1'b1);
        offer(1'b0, 4'hF, 1'b1);
        check("bubble_ctrl", 32'(out_ctrl_o), 32'd0);

        // Saturation from a clean counter
        do_reset();
        offer(1'b1, 4'h6, 1'b0);
        for (int i = 0; i < 6; i++) begin
            offer(1'b0, 4'h0, 1'b0);
            check("sat_seq", 32'(stall_cnt_o), sat_exp[i]);
        end

        // Asynchronous reset between edges with both entries full
        offer(1'b1, 4'hB, 1'b0);
        @(negedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        check("arst_out_valid", {31'd0, out_valid_o}, 32'd0);
        check("arst_out_ctrl", 32'(out_ctrl_o), 32'd0);
        check("arst_in_ready", {31'd0, in_ready_o}, 32'd1);
        check("arst_stall", 32'(stall_cnt_o), 32'd0);
        mq.delete();
        mcnt = 0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        offer(1'b1, 4'h9, 1'b1);
        check("post_rst_9", 32'(out_ctrl_o), 32'h9);
        offer(1'b0, 4'h0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            flush_i = ($urandom % 16) == 0;
            offer(1'($urandom), 4'($urandom), ($urandom % 4) != 0);
        end
        flush_i = 1'b0;
        offer(1'b0, 4'h0, 1'b1);
        offer(1'b0, 4'h0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
